mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port memory between the IF fetch port and the MA data port of the 5-stage RV32IM core.
//  Serialises requests through a small FSM: data wins, the served port is held off, and stall is released only when both are served.
//  Drives the combined stall fed to the pipeline's BUSYWAIT.
// PARAMETERS
//  IF_READ_CODE    4'b1010  MEM_READ code driven for instruction fetches (word load)
//  TIMEOUT_CYCLES  255      WAIT-state cycle limit; used only with ARB_TIMEOUT_EN
// PORTS
//  CLK           in   1   clock, rising edge
//  RST           in   1   asynchronous active-low reset
//  I_REQ         in   1   fetch request (level, held while I_BUSYWAIT=1)
//  I_ADDR        in   32  fetch address
//  I_RDATA       out  32  fetched word, registered
//  I_BUSYWAIT    out  1   fetch stall
//  D_READ        in   4   data load code, nonzero = load
//  D_WRITE       in   3   data store code, nonzero = store
//  D_ADDR        in   32  data address
//  D_WDATA       in   32  store data
//  D_RDATA       out  32  load data, registered
//  D_BUSYWAIT    out  1   data stall
//  BUSYWAIT_OUT  out  1   I_BUSYWAIT | D_BUSYWAIT, to pipeline
//  MEM_READ      out  4   memory read code
//  MEM_WRITE     out  3   memory write code
//  MEM_ADDR      out  32  memory address
//  MEM_WDATA     out  32  memory write data
//  MEM_RDATA     in   32  memory read data, valid when MEM_BUSYWAIT=0 in WAIT
//  MEM_BUSYWAIT  in   1   memory busy
//  ERR           out  1   sticky timeout flag
// BEHAVIOUR
//  Reset (RST=0, async): state=IDLE; MEM_READ=0, MEM_WRITE=0, MEM_ADDR=0, MEM_WDATA=0.
//   Also clears I_RDATA, D_RDATA, done_i, done_d, ERR. Busywaits remain combinational on the request inputs.
//  pend_d = (D_READ!=0 | D_WRITE!=0) & ~done_d; pend_i = I_REQ & ~done_i.
//  D_BUSYWAIT = pend_d; I_BUSYWAIT = pend_i; BUSYWAIT_OUT = OR of both (combinational).
//  FSM IDLE -> ISSUE -> WAIT -> IDLE; 1-bit owner register.
//  IDLE: if pend_d, latch D_ADDR/D_WDATA/D_READ/D_WRITE, owner=D, go to ISSUE.
//   Else if pend_i, latch I_ADDR with read code IF_READ_CODE, owner=I, go to ISSUE. Else stay.
//  Store has priority: if D_READ and D_WRITE are both nonzero, the latched read code is 0.
//  ISSUE: strobes driven from the latch; MEM_BUSYWAIT ignored; go to WAIT next cycle.
//  WAIT: strobes held. At the first edge with MEM_BUSYWAIT=0, capture MEM_RDATA into the owner's RDATA.
//   At that edge, set done_owner and go to IDLE; strobes become 0 in IDLE.
//  Minimum latency: request in cycle 0 -> busywait low in cycle 3.
//  RDATA is held until the next capture for the same port. Stores do not update D_RDATA.
//  done_i and done_d clear at any edge where BUSYWAIT_OUT=0 (the pipeline advances).
//   This prevents re-serving a request the stalled pipeline is still presenting.
//  A request withdrawn mid-transaction does not abort it: it completes and done is set.
//  Both requests in the same cycle: D is served first, then I. BUSYWAIT_OUT falls only after the second completes.
//  Async reset in ISSUE or WAIT drops the strobes immediately; the transaction is lost.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   An 8-bit counter runs in WAIT. After TIMEOUT_CYCLES cycles with MEM_BUSYWAIT=1, the transaction aborts.
//   Abort: strobes drop, owner RDATA=32'hDEADBEEF, done_owner=1, ERR=1 (sticky until reset), go to IDLE.
//  ARB_TIMEOUT_EN undefined: no counter; WAIT lasts indefinitely; ERR is tied to 0.
// TESTING
//  Reset: RST=0, all requests 0 -> MEM_READ/MEM_WRITE=0, I_RDATA=D_RDATA=0, ERR=0.
//   Assert I_REQ=1 during reset -> I_BUSYWAIT=1.
//  Fetch: I_REQ=1, I_ADDR=0x40, MEM_BUSYWAIT=0, MEM_RDATA=0x00500093 ->
//   MEM_READ=IF_READ_CODE and MEM_ADDR=0x40 in cycles 1-2; I_BUSYWAIT=0 in cycle 3; I_RDATA=0x00500093.
//  Contention: D_READ=4'b1010 @0x100 and fetch @0x44 in the same cycle, all held ->
//   Memory sees 0x100 then 0x44. BUSYWAIT_OUT=1 until cycle 6. Exactly two memory transactions; no repeat.
//  Slow store: D_WRITE=3'b110, D_ADDR=0x200, D_WDATA=0xCAFEF00D, MEM_BUSYWAIT=1 for 4 WAIT cycles ->
//   MEM_WRITE held for 5 cycles (ISSUE + 4 WAIT). D_BUSYWAIT falls at cycle 6. D_RDATA unchanged.
//  Mid-op reset: RST=0 during WAIT -> MEM_READ=0 immediately; after release, state IDLE, request re-served from ISSUE.
//  Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): MEM_BUSYWAIT stuck at 1 on a load ->
//   Abort after 8 WAIT cycles: ERR=1, D_RDATA=0xDEADBEEF. Without the macro, still waiting at cycle 50.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch port (I)
// and the data-access port (D) of the pipeline. Requests are serialised through an
// IDLE -> ISSUE -> WAIT FSM, data first, and the combined stall is held until every
// pending request has been served.
// Optional build macro: ARB_TIMEOUT_EN adds a WAIT-state watchdog that aborts a stuck
// transaction after TIMEOUT_CYCLES busy cycles and raises the sticky ERR flag.
module mem_arbiter #(
    parameter logic [3:0] IF_READ_CODE   = 4'b1010,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_REQ,
    input  logic [31:0] I_ADDR,
    output logic [31:0] I_RDATA,
    output logic        I_BUSYWAIT,
    input  logic [3:0]  D_READ,
    input  logic [2:0]  D_WRITE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    output logic [31:0] D_RDATA,
    output logic        D_BUSYWAIT,
    output logic        BUSYWAIT_OUT,
    output logic [3:0]  MEM_READ,
    output logic [2:0]  MEM_WRITE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_BUSYWAIT,
    output logic        ERR
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t      state_q;
    state_t      state_d;
    logic        owner_q;
    logic [3:0]  lat_read_q;
    logic [2:0]  lat_write_q;
    logic [31:0] lat_addr_q;
    logic [31:0] lat_wdata_q;
    logic        done_i_q;
    logic        done_d_q;

    logic        d_req;
    logic        pend_d;
    logic        pend_i;
    logic        start_d;
    logic        start_i;
    logic        finish;
    logic        abort;
    logic        strobes_on;

`ifdef ARB_TIMEOUT_EN
    localparam logic [31:0] ABORT_DATA   = 32'hDEADBEEF;
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic       err_q;
`else
    // Watchdog is compiled out; the parameter is kept so both builds share one interface.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // A port is pending while it requests and has not yet been served in this stall window.
    assign d_req        = (D_READ != 4'd0) || (D_WRITE != 3'd0);
    assign pend_d       = d_req && !done_d_q;
    assign pend_i       = I_REQ && !done_i_q;
    assign D_BUSYWAIT   = pend_d;
    assign I_BUSYWAIT   = pend_i;
    assign BUSYWAIT_OUT = pend_d || pend_i;

    // Strobes come straight from the latch in ISSUE/WAIT, so an async reset drops them at once.
    assign strobes_on = (state_q != S_IDLE);
    assign MEM_READ   = strobes_on ? lat_read_q  : 4'd0;
    assign MEM_WRITE  = strobes_on ? lat_write_q : 3'd0;
    assign MEM_ADDR   = strobes_on ? lat_addr_q  : 32'd0;
    assign MEM_WDATA  = strobes_on ? lat_wdata_q : 32'd0;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: data wins in IDLE; WAIT ends on memory ready (or watchdog abort).
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        start_i = 1'b0;
        finish  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_d) begin
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end else if (pend_i) begin
                    start_i = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!MEM_BUSYWAIT) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request latch: captures the winning port's command when leaving IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            owner_q     <= OWN_I;
            lat_read_q  <= 4'd0;
            lat_write_q <= 3'd0;
            lat_addr_q  <= 32'd0;
            lat_wdata_q <= 32'd0;
        end else if (start_d) begin
            owner_q     <= OWN_D;
            // A combined load/store code is treated as a store.
            lat_read_q  <= (D_WRITE != 3'd0) ? 4'd0 : D_READ;
            lat_write_q <= D_WRITE;
            lat_addr_q  <= D_ADDR;
            lat_wdata_q <= D_WDATA;
        end else if (start_i) begin
            owner_q     <= OWN_I;
            lat_read_q  <= IF_READ_CODE;
            lat_write_q <= 3'd0;
            lat_addr_q  <= I_ADDR;
            lat_wdata_q <= 32'd0;
        end
    end

    // Served flags: cleared when the pipeline advances, set when the owner's transaction ends.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            done_i_q <= 1'b0;
            done_d_q <= 1'b0;
        end else begin
            if (!BUSYWAIT_OUT) begin
                done_i_q <= 1'b0;
                done_d_q <= 1'b0;
            end
            if ((finish || abort) && (owner_q == OWN_D)) begin
                done_d_q <= 1'b1;
            end
            if ((finish || abort) && (owner_q == OWN_I)) begin
                done_i_q <= 1'b1;
            end
        end
    end

    // Read-data registers: hold the last word returned to each port; stores leave D_RDATA alone.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            I_RDATA <= 32'd0;
            D_RDATA <= 32'd0;
        end else if (finish) begin
            if ((owner_q == OWN_D) && (lat_write_q == 3'd0)) begin
                D_RDATA <= MEM_RDATA;
            end
            if (owner_q == OWN_I) begin
                I_RDATA <= MEM_RDATA;
            end
        end
`ifdef ARB_TIMEOUT_EN
        else if (abort) begin
            if (owner_q == OWN_D) begin
                D_RDATA <= ABORT_DATA;
            end else begin
                I_RDATA <= ABORT_DATA;
            end
        end
`endif
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog: counts busy cycles spent in WAIT; restarts on every new transaction.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= 8'd0;
        end else if (state_q != S_WAIT) begin
            cnt_q <= 8'd0;
        end else if (MEM_BUSYWAIT) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Sticky error flag, only cleared by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory transactions and
// expected read data; monitors pop and compare when the DUT presents them.
module tb_mem_arbiter;

    localparam logic [3:0] IFC = 4'b1010;

    logic        CLK = 1'b0;
    logic        RST;
    logic        I_REQ;
    logic [31:0] I_ADDR;
    logic [31:0] I_RDATA;
    logic        I_BUSYWAIT;
    logic [3:0]  D_READ;
    logic [2:0]  D_WRITE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic [31:0] D_RDATA;
    logic        D_BUSYWAIT;
    logic        BUSYWAIT_OUT;
    logic [3:0]  MEM_READ;
    logic [2:0]  MEM_WRITE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;
    logic        MEM_BUSYWAIT;
    logic        ERR;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .IF_READ_CODE  (IFC),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .I_REQ       (I_REQ),
        .I_ADDR      (I_ADDR),
        .I_RDATA     (I_RDATA),
        .I_BUSYWAIT  (I_BUSYWAIT),
        .D_READ      (D_READ),
        .D_WRITE     (D_WRITE),
        .D_ADDR      (D_ADDR),
        .D_WDATA     (D_WDATA),
        .D_RDATA     (D_RDATA),
        .D_BUSYWAIT  (D_BUSYWAIT),
        .BUSYWAIT_OUT(BUSYWAIT_OUT),
        .MEM_READ    (MEM_READ),
        .MEM_WRITE   (MEM_WRITE),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_WDATA   (MEM_WDATA),
        .MEM_RDATA   (MEM_RDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .ERR         (ERR)
    );

    typedef struct packed {
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        txn_q[$];
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic mon_prev_strobe = 1'b0;
    logic mon_prev_ib     = 1'b0;
    logic mon_prev_db     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic push_txn(input logic [3:0] rd, input logic [2:0] wr,
                            input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.rd    = rd;
        t.wr    = wr;
        t.addr  = addr;
        t.wdata = wdata;
        txn_q.push_back(t);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Transaction monitor: a new memory transaction starts when the strobes rise.
    initial begin : txn_mon
        logic cur;
        txn_t t;
        forever begin
            @(negedge CLK);
            cur = (MEM_READ != 4'd0) || (MEM_WRITE != 3'd0);
            if (RST === 1'b1 && cur && !mon_prev_strobe) begin
                if (txn_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL txn_unexpected: got addr %h rd %h wr %h, want none",
                             MEM_ADDR, MEM_READ, MEM_WRITE);
                end else begin
                    t = txn_q.pop_front();
                    check("txn_read", 32'(MEM_READ), 32'(t.rd));
                    check("txn_write", 32'(MEM_WRITE), 32'(t.wr));
                    check("txn_addr", MEM_ADDR, t.addr);
                    if (t.wr != 3'd0) check("txn_wdata", MEM_WDATA, t.wdata);
                end
            end
            mon_prev_strobe = cur;
        end
    end

    // Response monitor: a held request whose stall falls has been served.
    initial begin : rsp_mon
        logic [31:0] e;
        forever begin
            @(negedge CLK);
            if (RST === 1'b1) begin
                if (mon_prev_ib && !I_BUSYWAIT && I_REQ) begin
                    if (exp_i_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL i_rsp_unexpected: got %h, want none", I_RDATA);
                    end else begin
                        e = exp_i_q.pop_front();
                        check("i_rdata", I_RDATA, e);
                    end
                end
                if (mon_prev_db && !D_BUSYWAIT && (D_READ != 4'd0 || D_WRITE != 3'd0)) begin
                    if (exp_d_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL d_rsp_unexpected: got %h, want none", D_RDATA);
                    end else begin
                        e = exp_d_q.pop_front();
                        check("d_rdata", D_RDATA, e);
                    end
                end
            end
            mon_prev_ib = I_BUSYWAIT;
            mon_prev_db = D_BUSYWAIT;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of test, want finish before 100000");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        RST = 1'b0; I_REQ = 1'b0; I_ADDR = '0; D_READ = '0; D_WRITE = '0;
        D_ADDR = '0; D_WDATA = '0; MEM_RDATA = '0; MEM_BUSYWAIT = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_mem_read", 32'(MEM_READ), 32'd0);
        check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        check("rst_mem_addr", MEM_ADDR, 32'd0);
        check("rst_i_rdata", I_RDATA, 32'd0);
        check("rst_d_rdata", D_RDATA, 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_busy_out", 32'(BUSYWAIT_OUT), 32'd0);
        I_REQ = 1'b1;
        #1;
        check("rst_i_busy_comb", 32'(I_BUSYWAIT), 32'd1);
        check("rst_busy_out_comb", 32'(BUSYWAIT_OUT), 32'd1);
        I_REQ = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b1;

        // Single fetch, memory ready
        for (int c = 0; c <= 4; c++) begin
            step();
            if (c == 0) begin
                I_REQ = 1'b1; I_ADDR = 32'h40; MEM_BUSYWAIT = 1'b0; MEM_RDATA = 32'h00500093;
                push_txn(IFC, 3'd0, 32'h40, 32'h0);
                exp_i_q.push_back(32'h00500093);
            end
            if (c == 4) I_REQ = 1'b0;
            @(negedge CLK);
            if (c == 0) check("f_c0_i_busy", 32'(I_BUSYWAIT), 32'd1);
            if (c == 0) check("f_c0_mem_read", 32'(MEM_READ), 32'd0);
            if (c == 1 || c == 2) check("f_mem_read", 32'(MEM_READ), 32'(IFC));
            if (c == 1 || c == 2) check("f_mem_addr", MEM_ADDR, 32'h40);
            if (c == 3) check("f_c3_i_busy", 32'(I_BUSYWAIT), 32'd0);
        end

        // Contention: data and fetch in the same cycle
        for (int c = 0; c <= 8; c++) begin
            step();
            if (c == 0) begin
                D_READ = 4'b1010; D_ADDR = 32'h100; I_REQ = 1'b1; I_ADDR = 32'h44;
                MEM_BUSYWAIT = 1'b0; MEM_RDATA = 32'h11111111;
                push_txn(4'b1010, 3'd0, 32'h100, 32'h0);
                push_txn(IFC, 3'd0, 32'h44, 32'h0);
                exp_d_q.push_back(32'h11111111);
                exp_i_q.push_back(32'h22222222);
            end
            if (c == 5) MEM_RDATA = 32'h22222222;
            if (c == 7) begin D_READ = 4'd0; I_REQ = 1'b0; end
            @(negedge CLK);
            if (c <= 6) check("ct_busy_out", 32'(BUSYWAIT_OUT), 32'(c < 6));
            if (c == 1) check("ct_c1_addr", MEM_ADDR, 32'h100);
            if (c == 3) check("ct_c3_d_busy", 32'(D_BUSYWAIT), 32'd0);
            if (c == 3) check("ct_c3_i_busy", 32'(I_BUSYWAIT), 32'd1);
            if (c == 4) check("ct_c4_addr", MEM_ADDR, 32'h44);
            if (c == 4) check("ct_c4_read", 32'(MEM_READ), 32'(IFC));
        end

        // Load and store codes together: store wins, read strobe stays 0
        for (int c = 0; c <= 4; c++) begin
            step();
            if (c == 0) begin
                D_READ = 4'b1010; D_WRITE = 3'b010; D_ADDR = 32'h208; D_WDATA = 32'h12345678;
                MEM_RDATA = 32'h55555555;
                push_txn(4'd0, 3'b010, 32'h208, 32'h12345678);
                exp_d_q.push_back(32'h11111111);
            end
            if (c == 4) begin D_READ = 4'd0; D_WRITE = 3'd0; end
            @(negedge CLK);
            if (c == 1) check("pr_mem_read", 32'(MEM_READ), 32'd0);
            if (c == 1) check("pr_mem_write", 32'(MEM_WRITE), 32'(3'b010));
        end

        // Slow store: 4 WAIT cycles
        for (int c = 0; c <= 7; c++) begin
            step();
            if (c == 0) begin
                D_WRITE = 3'b110; D_ADDR = 32'h200; D_WDATA = 32'hCAFEF00D;
                MEM_BUSYWAIT = 1'b1; MEM_RDATA = 32'h99999999;
                push_txn(4'd0, 3'b110, 32'h200, 32'hCAFEF00D);
                exp_d_q.push_back(32'h11111111);
            end
            if (c == 5) MEM_BUSYWAIT = 1'b0;
            if (c == 7) D_WRITE = 3'd0;
            @(negedge CLK);
            if (c >= 1 && c <= 5) check("ss_mem_write", 32'(MEM_WRITE), 32'(3'b110));
            if (c == 5) check("ss_c5_d_busy", 32'(D_BUSYWAIT), 32'd1);
            if (c == 6) check("ss_c6_d_busy", 32'(D_BUSYWAIT), 32'd0);
            if (c == 6) check("ss_mem_write_off", 32'(MEM_WRITE), 32'd0);
        end

        // Reset during WAIT, then the held request is served again
        for (int c = 0; c <= 7; c++) begin
            step();
            if (c == 0) begin
                D_READ = 4'b1010; D_ADDR = 32'h300; MEM_BUSYWAIT = 1'b1; MEM_RDATA = 32'h33333333;
                push_txn(4'b1010, 3'd0, 32'h300, 32'h0);
                push_txn(4'b1010, 3'd0, 32'h300, 32'h0);
                exp_d_q.push_back(32'h33333333);
            end
            if (c == 3) begin RST = 1'b1; MEM_BUSYWAIT = 1'b0; end
            if (c == 7) D_READ = 4'd0;
            @(negedge CLK);
            if (c == 2) begin
                check("mr_wait_read", 32'(MEM_READ), 32'(4'b1010));
                #2 RST = 1'b0;
                #1;
                check("mr_async_read", 32'(MEM_READ), 32'd0);
                check("mr_async_addr", MEM_ADDR, 32'd0);
            end
            if (c == 3) check("mr_idle_read", 32'(MEM_READ), 32'd0);
            if (c == 4) check("mr_reissue_addr", MEM_ADDR, 32'h300);
            if (c == 6) check("mr_c6_d_busy", 32'(D_BUSYWAIT), 32'd0);
        end

        // Memory stuck busy on a load
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c <= 12; c++) begin
            step();
            if (c == 0) begin
                D_READ = 4'b1010; D_ADDR = 32'h400; MEM_BUSYWAIT = 1'b1;
                push_txn(4'b1010, 3'd0, 32'h400, 32'h0);
                exp_d_q.push_back(32'hDEADBEEF);
            end
            if (c == 11) begin D_READ = 4'd0; MEM_BUSYWAIT = 1'b0; end
            @(negedge CLK);
            if (c == 9) check("to_c9_d_busy", 32'(D_BUSYWAIT), 32'd1);
            if (c == 9) check("to_c9_err", 32'(ERR), 32'd0);
            if (c == 10) check("to_c10_d_busy", 32'(D_BUSYWAIT), 32'd0);
            if (c == 10) check("to_c10_err", 32'(ERR), 32'd1);
            if (c == 12) check("to_err_sticky", 32'(ERR), 32'd1);
            if (c == 12) check("to_read_off", 32'(MEM_READ), 32'd0);
        end
`else
        for (int c = 0; c <= 50; c++) begin
            step();
            if (c == 0) begin
                D_READ = 4'b1010; D_ADDR = 32'h400; MEM_BUSYWAIT = 1'b1;
                push_txn(4'b1010, 3'd0, 32'h400, 32'h0);
            end
            @(negedge CLK);
            if (c == 50) check("nt_c50_d_busy", 32'(D_BUSYWAIT), 32'd1);
            if (c == 50) check("nt_c50_read", 32'(MEM_READ), 32'(4'b1010));
            if (c == 50) check("nt_c50_err", 32'(ERR), 32'd0);
        end
        #2 RST = 1'b0; D_READ = 4'd0; MEM_BUSYWAIT = 1'b0;
        #1;
        check("nt_rst_read", 32'(MEM_READ), 32'd0);
        step();
        RST = 1'b1;
`endif

        // Final reset clears the flag and read data; nothing may be left outstanding
        repeat (2) step();
        RST = 1'b0;
        #1;
        check("end_err", 32'(ERR), 32'd0);
        check("end_d_rdata", D_RDATA, 32'd0);
        check("end_txn_left", 32'(txn_q.size()), 32'd0);
        check("end_exp_i_left", 32'(exp_i_q.size()), 32'd0);
        check("end_exp_d_left", 32'(exp_d_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
